// File: rtl/sm83_reg_bus_eval_rd.sv
// Precharge/evaluate read sequencer for a 4-bit dynamic register bus slice.
// Define SM83_REG_BUS_MONO_CHECK_EN to build the sticky bus monotonicity checker.
module sm83_reg_bus_eval_rd #(
    parameter int PCH_CYCLES = 2,
    parameter int NREG       = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rd_req,
    input  logic [$clog2(NREG)-1:0] rd_sel,
    input  logic                    rd_zero,
    input  logic [3:0]              bus_y,
    output logic                    pch_n,
    output logic                    c_zero,
    output logic [NREG-1:0]         rd_oe,
    output logic                    rd_ack,
    output logic [3:0]              rd_data,
    output logic                    rd_vld,
    output logic                    bus_err
);
    localparam int         SW      = $clog2(NREG);
    localparam logic [3:0] PCH_MAX = 4'(PCH_CYCLES);
    localparam logic [SW:0] SEL_LIM = (SW+1)'(NREG);

    typedef enum logic [1:0] {PCH, EVAL, SAMP, DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    pch_cnt, pch_cnt_nxt;
    logic [SW-1:0] sel_q;
    logic          zero_q;
    logic          pch_ok;
    logic          sel_ok;
    logic          drive;

    assign pch_ok = (pch_cnt >= PCH_MAX);
    assign sel_ok = ({1'b0, sel_q} < SEL_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= PCH;
            pch_cnt <= 4'd0;
            sel_q   <= '0;
            zero_q  <= 1'b0;
            rd_data <= 4'd0;
        end else begin
            state   <= state_nxt;
            pch_cnt <= pch_cnt_nxt;
            if (rd_ack) begin
                sel_q  <= rd_sel;
                zero_q <= rd_zero;
            end
            if (state == SAMP)
                rd_data <= bus_y;
        end
    end

    always_comb begin
        state_nxt   = state;
        pch_cnt_nxt = pch_cnt;
        rd_ack      = 1'b0;
        rd_vld      = 1'b0;
        drive       = 1'b0;
        case (state)
            PCH: begin
                if (!pch_ok)
                    pch_cnt_nxt = pch_cnt + 4'd1;
                if (rd_req && pch_ok) begin
                    rd_ack    = 1'b1;
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                drive     = 1'b1;
                state_nxt = SAMP;
            end
            SAMP: begin
                drive     = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                rd_vld      = 1'b1;
                // DONE already precharges the bus, so it counts toward the next read
                pch_cnt_nxt = 4'd1;
                state_nxt   = PCH;
            end
            default: state_nxt = PCH;
        endcase
    end

    // All bus drive outputs derive from the state register, so the async reset
    // drops enables and restarts precharge in the same timestep.
    always_comb begin
        pch_n  = drive;
        c_zero = drive && zero_q;
        rd_oe  = '0;
        if (drive && !zero_q && sel_ok)
            rd_oe = NREG'(1) << sel_q;
    end

`ifdef SM83_REG_BUS_MONO_CHECK_EN
    logic [3:0] eval_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eval_y  <= 4'd0;
            bus_err <= 1'b0;
        end else begin
            if (state == EVAL)
                eval_y <= bus_y;
            // a discharged bit can never recharge while the source is driving
            if (state == SAMP && |(bus_y & ~eval_y))
                bus_err <= 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_sm83_reg_bus_eval_rd.sv
// Bench for sm83_reg_bus_eval_rd: directed and random reads against a cycle-timestamp model.
module tb_sm83_reg_bus_eval_rd;
    localparam int PCH = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rd_req;
    logic [2:0] rd_sel, rd_sel2;
    logic       rd_zero;
    logic [3:0] bus_y;

    logic       pch_n, c_zero, rd_ack, rd_vld, bus_err;
    logic [7:0] rd_oe;
    logic [3:0] rd_data;

    logic       pch_n2, c_zero2, rd_ack2, rd_vld2, bus_err2;
    logic [4:0] rd_oe2;
    logic [3:0] rd_data2;

    int checks = 0;
    int errors = 0;

    // model state: timestamps of reset release and last acknowledge
    int         cyc = 0;
    int         rel = 0;
    int         ack_cyc = -1000;
    logic [2:0] l_sel = 3'd0, l_sel2 = 3'd0;
    logic       l_zero = 1'b0;
    logic [3:0] y_eval = 4'd0;
    logic [3:0] exp_data = 4'd0;
    logic       mono = 1'b0;

    always #5 clk = ~clk;

    sm83_reg_bus_eval_rd #(.PCH_CYCLES(PCH), .NREG(8)) dut (
        .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_zero(rd_zero), .bus_y(bus_y), .pch_n(pch_n), .c_zero(c_zero),
        .rd_oe(rd_oe), .rd_ack(rd_ack), .rd_data(rd_data), .rd_vld(rd_vld),
        .bus_err(bus_err)
    );

    sm83_reg_bus_eval_rd #(.PCH_CYCLES(PCH), .NREG(5)) dut2 (
        .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_sel(rd_sel2),
        .rd_zero(rd_zero), .bus_y(bus_y), .pch_n(pch_n2), .c_zero(c_zero2),
        .rd_oe(rd_oe2), .rd_ack(rd_ack2), .rd_data(rd_data2), .rd_vld(rd_vld2),
        .bus_err(bus_err2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Settle, compare every output with the model, advance the model, then move to the next cycle.
    task automatic cycle_chk();
        int         d, earliest;
        logic       e_ack, e_pch_n, e_cz, e_vld, e_err, act;
        logic [7:0] e_oe;
        logic [4:0] e_oe2;
        #1;
        d = cyc - ack_cyc;
        earliest = rel + PCH;
        if (ack_cyc + 3 + PCH > earliest) earliest = ack_cyc + 3 + PCH;
        if (!reset_n) begin
            ack_cyc = -1000; exp_data = 4'd0; mono = 1'b0;
            e_ack = 0; e_pch_n = 0; e_cz = 0; e_vld = 0; e_oe = 0; e_oe2 = 0;
        end else begin
            act     = (d == 1 || d == 2);
            e_ack   = rd_req && !(d >= 1 && d <= 3) && (cyc >= earliest);
            e_pch_n = act;
            e_cz    = act && l_zero;
            e_vld   = (d == 3);
            e_oe    = (act && !l_zero) ? (8'd1 << l_sel) : 8'd0;
            e_oe2   = (act && !l_zero && l_sel2 < 3'd5) ? (5'd1 << l_sel2) : 5'd0;
        end
`ifdef SM83_REG_BUS_MONO_CHECK_EN
        e_err = mono;
`else
        e_err = 1'b0;
`endif
        chk("rd_ack",  rd_ack,  e_ack);
        chk("pch_n",   pch_n,   e_pch_n);
        chk("c_zero",  c_zero,  e_cz);
        chk("rd_oe",   rd_oe,   e_oe);
        chk("rd_vld",  rd_vld,  e_vld);
        chk("rd_data", rd_data, exp_data);
        chk("bus_err", bus_err, e_err);
        chk("rd_oe_n5",  rd_oe2,  e_oe2);
        chk("c_zero_n5", c_zero2, e_cz);
        chk("rd_vld_n5", rd_vld2, e_vld);
        if (reset_n) begin
            if (d == 1) y_eval = bus_y;
            if (d == 2) begin
                exp_data = bus_y;
                if (|(bus_y & ~y_eval)) mono = 1'b1;
            end
            if (e_ack) begin
                ack_cyc = cyc; l_sel = rd_sel; l_sel2 = rd_sel2; l_zero = rd_zero;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_until(input int phase, input string tag);
        int n = 0;
        while (!(reset_n && cyc - ack_cyc == phase) && n < 20) begin
            cycle_chk();
            n++;
        end
        chk(tag, (cyc - ack_cyc == phase), 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; rd_req = 1'b0; rd_sel = 3'd0; rd_sel2 = 3'd0;
        rd_zero = 1'b0; bus_y = 4'hF;
        @(posedge clk); cyc++; #1;
        cycle_chk();
        cycle_chk();

        // steady request, source 3, bus reads 4'hA; two back-to-back reads
        reset_n = 1'b1; rel = cyc;
        rd_req = 1'b1; rd_sel = 3'd3; rd_sel2 = 3'd3; bus_y = 4'hA;
        for (int i = 0; i < 12; i++) cycle_chk();
        chk("first_ack_cycle", ack_cyc - rel >= 0 ? 1'b1 : 1'b0, 1'b1);
        chk("rd_data_A", rd_data, 4'hA);

        // zero read
        rd_zero = 1'b1; rd_sel = 3'd5; rd_sel2 = 3'd5; bus_y = 4'hB;
        for (int i = 0; i < 7; i++) cycle_chk();

        // out-of-range source on the 5-source instance
        rd_zero = 1'b0; rd_sel = 3'd1; rd_sel2 = 3'd7; bus_y = 4'h6;
        for (int i = 0; i < 7; i++) cycle_chk();

        // rising bit between EVAL and SAMP
        run_until(1, "reach_eval");
        bus_y = 4'h0; cycle_chk();
        bus_y = 4'h1; cycle_chk();
        bus_y = 4'h1;
        for (int i = 0; i < 4; i++) cycle_chk();

        for (int i = 0; i < 300; i++) begin
            rd_req  = ($urandom_range(0, 9) < 7);
            rd_sel  = 3'($urandom);
            rd_sel2 = 3'($urandom_range(3, 7));
            rd_zero = ($urandom_range(0, 3) == 0);
            bus_y   = 4'($urandom);
            cycle_chk();
        end

        // reset asserted in SAMP
        rd_req = 1'b1; rd_zero = 1'b0; rd_sel = 3'd6; rd_sel2 = 3'd2;
        run_until(2, "reach_samp");
        reset_n = 1'b0;
        cycle_chk();
        cycle_chk();
        reset_n = 1'b1; rel = cyc;
        for (int i = 0; i < 10; i++) cycle_chk();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
